uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have ports: Clk input 1 clock; Rst input 1 reset, synchronous, active-high.
REQ-002 SHALL have Req input 4: per-requester byte-pending request, held until Ack.
REQ-003 SHALL have Dat input 32: requester i byte on Dat[8i+7:8i], stable while Req[i]=1.
REQ-004 SHALL have Last input 4: requester i byte ends a packet; sampled with Dat.
REQ-005 SHALL have Ack output 4: one-cycle pulse, byte of requester i accepted.
REQ-006 SHALL have THR output 8: holding byte to transmit state machine.
REQ-007 SHALL have TF_EF output 1: holding register empty flag, 1 = empty.
REQ-008 SHALL have TF_RE input 1: one-cycle read strobe from transmit state machine.
REQ-009 SHALL have Owner output 2: index of requester whose byte is in THR or last granted.
REQ-010 SHALL have Locked output 1 and LockTO output 1: lock held; one-cycle timeout pulse (with UART_TX_ARB_LOCK_EN only, else tied 0).

Function
REQ-011 SHALL hold one byte in THR with Full flag; TF_EF = ~Full, registered.
REQ-012 SHALL arbitrate when Full=0 or TF_RE=1; eligible = Req & ~Ack (requester acked this cycle masked).
REQ-013 SHALL use round-robin priority starting at Owner+1 mod 4, wrapping 3->0.
REQ-014 SHALL on grant to i at a clock edge: THR<=Dat[i], Full<=1, Owner<=i, Ack[i]<=1 for exactly one cycle; latency Req-to-Ack 1 cycle when empty.
REQ-015 SHALL on TF_RE with no grant: Full<=0; on TF_RE with simultaneous grant: Full stays 1, THR replaced.
REQ-016 SHALL keep THR unchanged while Full=1 and TF_RE=0 (transmit state machine loads its shift register from THR before TF_RE).
REQ-017 SHALL ignore TF_RE while Full=0 (no underflow, no state change).
REQ-018 SHALL grant at most one requester per cycle; Ack one-hot or zero.

Reset
REQ-019 SHALL on Rst: Full=0 (TF_EF=1), THR=8'h00, Ack=0, Owner=3 (requester 0 first priority), Locked=0, LockTO=0, timeout counter=0.
REQ-020 SHALL on Rst mid-operation discard held byte; no Ack for any request pending at reset.

Configuration
REQ-021 SHALL compile packet lock when macro UART_TX_ARB_LOCK_EN defined; otherwise pure per-byte round-robin, Locked=LockTO=0.
REQ-022 With UART_TX_ARB_LOCK_EN: states sFree, sLock; grant with Last=0 in sFree -> sLock, Locked=1; in sLock only Owner eligible.
REQ-023 With UART_TX_ARB_LOCK_EN: grant with Last=1 in sLock -> sFree; grant with Last=1 in sFree stays sFree.
REQ-024 With UART_TX_ARB_LOCK_EN: 8-bit counter increments each cycle in sLock with Req[Owner]=0, clears on any grant; at 255 -> sFree, LockTO pulse one cycle, counter cleared.
REQ-025 Timeout and grant in same cycle impossible (counter only counts with Req[Owner]=0); Rst overrides all.

Structure
REQ-026 SHALL place requester count (4), index width (2), lock-timeout terminal count (255), and state encodings in shared package uart_pkg.
REQ-027 SHALL implement round-robin priority pick as sub-module uart_rr_pick (4-bit request, 2-bit last index -> one-hot grant, valid); combinational.

Verification
REQ-028 Reset, Req=4'b0001, Dat[7:0]=8'h55 -> next cycle Ack=4'b0001, THR=8'h55, TF_EF=0, Owner=0.
REQ-029 Req=4'b1111 held, TF_RE pulsed every 4 cycles -> grant order 0,1,2,3,0; each Ack one cycle.
REQ-030 Full, TF_RE=1 with Req[2]=1, Dat=8'hA3 same cycle -> TF_EF stays 0, THR=8'hA3, Ack[2] pulse.
REQ-031 TF_RE while TF_EF=1 -> no change to THR, Owner, Ack.
REQ-032 LOCK_EN: req 1 sends Last=0, req 0,2 pending -> only req 1 granted until Last=1 byte; then req 2 next.
REQ-033 LOCK_EN: locked owner drops Req for 255 cycles -> LockTO pulse, Locked=0, pending req 3 granted next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, lock states and one-hot encoder for the UART TX arbiter
package uart_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam logic [7:0] LOCK_TO = 8'd255;
  typedef enum logic {sFree, sLock} lock_state_t;
  function automatic logic [IDX_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < N_REQ; i++) if (oh[i]) oh2idx = IDX_W'(i);
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin pick, priority starts at last+1
module uart_rr_pick
  import uart_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);
  always_comb begin
    gnt = '0;
    for (int k = N_REQ; k > 0; k--)
      if (req[last + IDX_W'(k)]) gnt = N_REQ'(1) << (last + IDX_W'(k));
  end
  assign valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: 4-way round-robin arbiter feeding a one-byte UART TX holding register
// Optional packet lock with idle timeout when UART_TX_ARB_LOCK_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_REQ-1:0] Req,
  input  logic [31:0]      Dat,
  input  logic [N_REQ-1:0] Last,
  output logic [N_REQ-1:0] Ack,
  output logic [7:0]       THR,
  output logic             TF_EF,
  input  logic             TF_RE,
  output logic [IDX_W-1:0] Owner,
  output logic             Locked,
  output logic             LockTO
);
  logic full, vld, grant;
  logic [N_REQ-1:0] elig, gnt;
  logic [IDX_W-1:0] gidx;
  assign grant = (~full | TF_RE) & vld;
  assign gidx = oh2idx(gnt);
  assign TF_EF = ~full;
  uart_rr_pick u_pick (.req(elig), .last(Owner), .gnt(gnt), .valid(vld));
  always_ff @(posedge Clk) begin
    if (Rst) begin
      full <= 1'b0;
      THR <= 8'h00;
      Ack <= '0;
      Owner <= IDX_W'(N_REQ - 1);
    end else begin
      Ack <= grant ? gnt : '0;
      if (grant) begin
        THR <= Dat[{gidx, 3'b000} +: 8];
        Owner <= gidx;
        full <= 1'b1;
      end else if (TF_RE) full <= 1'b0;
    end
  end
`ifdef UART_TX_ARB_LOCK_EN
  lock_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic to_n;
  // While locked only the packet owner may win, and never in its own Ack cycle.
  assign elig = Req & ~Ack & (state == sLock ? N_REQ'(1) << Owner : '1);
  assign Locked = state == sLock;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    to_n = 1'b0;
    if (grant) begin
      cnt_n = '0;
      state_n = Last[gidx] ? sFree : sLock;
    end else if (state == sLock && !Req[Owner]) begin
      to_n = cnt == LOCK_TO - 8'd1;
      cnt_n = to_n ? '0 : cnt + 8'd1;
      state_n = to_n ? sFree : sLock;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= sFree;
      cnt <= '0;
      LockTO <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      LockTO <= to_n;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^Last;
  assign elig = Req & ~Ack;
  assign Locked = 1'b0;
  assign LockTO = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic Clk = 0, Rst = 1, TF_RE = 0;
  logic [3:0] Req = 0, Last = 0, Ack;
  logic [31:0] Dat = 0;
  logic [7:0] THR;
  logic TF_EF, Locked, LockTO;
  logic [1:0] Owner;
  int cmp = 0, mis = 0;

  uart_tx_arbiter dut (.Clk(Clk), .Rst(Rst), .Req(Req), .Dat(Dat), .Last(Last), .Ack(Ack),
    .THR(THR), .TF_EF(TF_EF), .TF_RE(TF_RE), .Owner(Owner), .Locked(Locked), .LockTO(LockTO));

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1; Req = 0; TF_RE = 0; Last = 0;
    tick(); tick();
    Rst = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_ef", TF_EF, 1); chk("rst_thr", THR, 0); chk("rst_ack", Ack, 0);
    chk("rst_owner", Owner, 3); chk("rst_locked", Locked, 0); chk("rst_to", LockTO, 0);

    Req = 4'b0001; Dat = 32'h0000_0055;
    tick();
    chk("first_ack", Ack, 4'b0001); chk("first_thr", THR, 8'h55);
    chk("first_ef", TF_EF, 0); chk("first_owner", Owner, 0);
    Req = 0;
    tick();
    chk("ack_pulse", Ack, 0); chk("hold_thr", THR, 8'h55);
    TF_RE = 1;
    tick();
    TF_RE = 0;
    chk("drain_ef", TF_EF, 1); chk("drain_thr", THR, 8'h55);
    TF_RE = 1;
    tick();
    TF_RE = 0;
    chk("re_empty_thr", THR, 8'h55); chk("re_empty_owner", Owner, 0);
    chk("re_empty_ack", Ack, 0); chk("re_empty_ef", TF_EF, 1);

    // Round-robin with all requests held, drained every 4 cycles
    do_reset();
    Req = 4'b1111; Dat = 32'hD3C2_B1A0;
    tick();
    chk("rr0_ack", Ack, 4'b0001); chk("rr0_thr", THR, 8'hA0);
    for (int g = 1; g <= 4; g++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("rr_idle_ack", Ack, 0); chk("rr_idle_ef", TF_EF, 0);
      end
      TF_RE = 1;
      tick();
      TF_RE = 0;
      chk("rr_ack", Ack, 4'b0001 << (g % 4)); chk("rr_owner", Owner, g % 4);
      chk("rr_thr", THR, 8'hA0 + 8'h11 * (g % 4));
    end

    // Read and grant in the same cycle keep the register full
    Req = 4'b0100; Dat = 32'h00A3_0000; TF_RE = 1;
    tick();
    TF_RE = 0; Req = 0;
    chk("swap_ef", TF_EF, 0); chk("swap_thr", THR, 8'hA3);
    chk("swap_ack", Ack, 4'b0100); chk("swap_owner", Owner, 2);
    Req = 4'b0010; Dat = 32'h0000_7700;
    tick();
    chk("full_block_ack", Ack, 0); chk("full_block_thr", THR, 8'hA3);

    // Reset mid-operation with a request pending
    Rst = 1;
    tick();
    Rst = 0; Req = 0;
    chk("mid_rst_ef", TF_EF, 1); chk("mid_rst_thr", THR, 0);
    chk("mid_rst_ack", Ack, 0); chk("mid_rst_owner", Owner, 3);
    tick();
    chk("post_rst_ack", Ack, 0);

    // Requester acked this cycle is masked from the next arbitration
    Req = 4'b0001; Dat = 32'h0000_0011; TF_RE = 1;
    tick();
    chk("mask_ack1", Ack, 4'b0001);
    tick();
    chk("mask_ack2", Ack, 0); chk("mask_ef", TF_EF, 1);
    tick();
    chk("mask_ack3", Ack, 4'b0001);
    TF_RE = 0; Req = 0;

`ifdef UART_TX_ARB_LOCK_EN
    // Packet lock: requester 1 holds the channel until its Last byte
    do_reset();
    Req = 4'b0010; Last = 4'b0000; Dat = 32'h0000_1100;
    tick();
    chk("lk_ack", Ack, 4'b0010); chk("lk_locked", Locked, 1);
    Req = 4'b0111; TF_RE = 1;
    tick();
    TF_RE = 0;
    chk("lk_masked_ack", Ack, 0); chk("lk_drained", TF_EF, 1);
    tick();
    chk("lk_only_owner", Ack, 4'b0010); chk("lk_owner", Owner, 1);
    Last = 4'b0010; TF_RE = 1;
    tick();
    TF_RE = 0;
    chk("lk_hold_ack", Ack, 0); chk("lk_still", Locked, 1);
    tick();
    chk("lk_last_ack", Ack, 4'b0010); chk("lk_freed", Locked, 0);
    Req = 4'b0101; Last = 0; TF_RE = 1;
    tick();
    TF_RE = 0; Req = 0;
    chk("lk_next_ack", Ack, 4'b0100); chk("lk_next_owner", Owner, 2);

    // Lock timeout after the owner goes idle
    do_reset();
    Req = 4'b0010; Last = 0;
    tick();
    chk("to_locked", Locked, 1);
    Req = 4'b1000; Dat = 32'h3300_0000; TF_RE = 1;
    tick();
    TF_RE = 0;
    for (int c = 0; c < 253; c++) tick();
    chk("to_pre_locked", Locked, 1); chk("to_pre_pulse", LockTO, 0); chk("to_pre_ack", Ack, 0);
    tick();
    chk("to_pulse", LockTO, 1); chk("to_unlocked", Locked, 0); chk("to_ack0", Ack, 0);
    tick();
    chk("to_pulse_end", LockTO, 0); chk("to_grant", Ack, 4'b1000);
    chk("to_owner", Owner, 3); chk("to_thr", THR, 8'h33);
    Req = 0;
`else
    Req = 4'b0010; Last = 0; TF_RE = 1;
    tick(); tick();
    chk("nolock_locked", Locked, 0); chk("nolock_to", LockTO, 0);
    Req = 0; TF_RE = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
